// File: rtl/sseg_scan_driver_pkg.sv
// Shared segment encodings and anode polarity helper for the seven-segment scan driver.
package sseg_scan_driver_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_MAX = 8;

  // Segment order is a..g with a at index 0; a 0 lights the segment.
  typedef logic [0:SEG_W-1] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Maps an active-high one-hot (or all-zero) select onto the board's anode polarity.
  function automatic logic [AN_MAX-1:0] an_drive(input logic [AN_MAX-1:0] onehot,
                                                  input logic active_low);
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg_decode
  import sseg_scan_driver_pkg::*;
(
  input  logic [3:0] value,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_TABLE[value];
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame snapshots,
// leading-zero blanking and a display enable.
module sseg_scan_driver
  import sseg_scan_driver_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [0:6]            sseg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic             AN_LOW   = (AN_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF = N_DIGITS'(an_drive(AN_MAX'(0), AN_LOW));

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic                  valid;
  logic                  load_pending;

  logic                  wrap_c;
  logic                  load_c;
  logic [3:0]            cur_digit_c;
  logic                  cur_dp_c;
  logic                  lz_c;
  logic                  zero_run_c;
  logic [0:6]            dec_seg_c;
  logic [N_DIGITS-1:0]   an_onehot_c;

  assign wrap_c      = (cnt == CNT_LAST);
  assign load_c      = load_pending | (wrap_c & (idx == IDX_LAST));
  assign an_onehot_c = N_DIGITS'(1) << idx;

  // Select the scanned digit and decide whether it sits inside the leading-zero run.
  always_comb begin
    cur_digit_c = 4'd0;
    cur_dp_c    = 1'b0;
    lz_c        = 1'b0;
    zero_run_c  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c & (snap_digits[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        cur_digit_c = snap_digits[4*i +: 4];
        cur_dp_c    = snap_dp[i];
        lz_c        = zero_run_c & (i != 0);
      end
    end
  end

  hex7seg_decode u_decode (
    .value (cur_digit_c),
    .seg   (dec_seg_c)
  );

  // The priming load holds the counter so the first frame gives every digit a full slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      snap_digits  <= '0;
      snap_dp      <= '0;
      valid        <= 1'b0;
      load_pending <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= load_c;
      if (load_c) begin
        snap_digits  <= digits;
        snap_dp      <= dp_in;
        valid        <= 1'b1;
        load_pending <= 1'b0;
      end
      if (!load_pending) begin
        if (wrap_c) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg <= SEG_BLANK;
      dp   <= 1'b1;
      an   <= AN_OFF;
    end else if (!valid || !en) begin
      sseg <= SEG_BLANK;
      dp   <= 1'b1;
      an   <= AN_OFF;
    end else begin
      sseg <= (blank_lz && lz_c) ? SEG_BLANK : dec_seg_c;
      dp   <= ~cur_dp_c;
      an   <= N_DIGITS'(an_drive(AN_MAX'(an_onehot_c), AN_LOW));
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: a 4-digit active-low-anode instance and a 1-digit
// active-high-anode instance checked every cycle against a frame/slot model.
module tb_sseg_scan_driver;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp_in = 4'b0000;
  logic        blank_lz = 1'b0;
  logic        en = 1'b1;

  logic [0:6]  sseg0;
  logic        dp0;
  logic [3:0]  an0;
  logic        fs0;
  logic [0:6]  sseg1;
  logic        dp1;
  logic [0:0]  an1;
  logic        fs1;

  int total = 0;
  int bad = 0;
  int ed = 0;

  always #5 clk = ~clk;

  sseg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .AN_ACTIVE_LOW(1)) dut0 (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .blank_lz(blank_lz), .en(en),
    .sseg(sseg0), .dp(dp0), .an(an0), .frame_start(fs0)
  );

  sseg_scan_driver #(.N_DIGITS(1), .SCAN_DIV(3), .AN_ACTIVE_LOW(0)) dut1 (
    .clk(clk), .rst(rst), .digits(digits[3:0]), .dp_in(dp_in[0:0]), .blank_lz(blank_lz),
    .en(en), .sseg(sseg1), .dp(dp1), .an(an1), .frame_start(fs1)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Output after edge k (counted from reset release): the first edge only primes the
  // snapshot, then each digit gets s cycles in turn using the frame snapshot.
  function automatic exp_t model_out(input int k, input int s, input int n, input logic e,
                                     input logic blz, input logic [31:0] sd,
                                     input logic [7:0] sdp, input logic alow);
    exp_t r;
    int pos;
    logic [7:0] oh;
    r.seg = 7'h7f;
    r.dp  = 1'b1;
    r.an  = alow ? 8'hff : 8'h00;
    if (k >= 2 && e) begin
      pos  = ((k - 2) / s) % n;
      oh   = 8'(1) << pos;
      r.an = alow ? ~oh : oh;
      r.dp = ~sdp[pos];
      if (pos > 0 && blz && (sd >> (4 * pos)) == 0) r.seg = 7'h7f;
      else r.seg = seg_ref(sd[4*pos +: 4]);
    end
    return r;
  endfunction

  int          k = 0;
  exp_t        e0 = '{seg: 7'h7f, dp: 1'b1, an: 8'hff};
  exp_t        e1 = '{seg: 7'h7f, dp: 1'b1, an: 8'h00};
  logic        fx0 = 1'b0;
  logic        fx1 = 1'b0;
  logic [31:0] sd0 = '0;
  logic [7:0]  sdp0 = '0;
  logic [31:0] sd1 = '0;
  logic [7:0]  sdp1 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k   = 0;
      e0  = model_out(0, 4, 4, 1'b1, 1'b0, 32'(0), 8'(0), 1'b1);
      e1  = model_out(0, 3, 1, 1'b1, 1'b0, 32'(0), 8'(0), 1'b0);
      fx0 = 1'b0;
      fx1 = 1'b0;
    end else begin
      k++;
      e0  = model_out(k, 4, 4, en, blank_lz, sd0, sdp0, 1'b1);
      e1  = model_out(k, 3, 1, en, blank_lz, sd1, sdp1, 1'b0);
      fx0 = ((k - 1) % 16 == 0);
      fx1 = ((k - 1) % 3 == 0);
      if (fx0) begin sd0 = 32'(digits); sdp0 = 8'(dp_in); end
      if (fx1) begin sd1 = 32'(digits[3:0]); sdp1 = 8'(dp_in[0]); end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m4_seg", 32'(sseg0), 32'(e0.seg));
    chk("m4_dp",  32'(dp0),   32'(e0.dp));
    chk("m4_an",  32'(an0),   32'(e0.an[3:0]));
    chk("m4_fs",  32'(fs0),   32'(fx0));
    chk("m1_seg", 32'(sseg1), 32'(e1.seg));
    chk("m1_dp",  32'(dp1),   32'(e1.dp));
    chk("m1_an",  32'(an1),   32'(e1.an[0]));
    chk("m1_fs",  32'(fs1),   32'(fx1));
  end

  task automatic goto(input int t);
    while (ed < t) begin
      @(posedge clk);
      ed++;
    end
    #1;
  endtask

  task automatic lit4(input string name, input logic [3:0] an_w, input logic [6:0] seg_w);
    chk({name, "_an"},  32'(an0),   32'(an_w));
    chk({name, "_seg"}, 32'(sseg0), 32'(seg_w));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ed = 0;

    goto(1);
    chk("first_fs4", 32'(fs0), 32'(1));
    chk("first_fs1", 32'(fs1), 32'(1));
    lit4("first_blank", 4'b1111, 7'b1111111);
    goto(2);
    lit4("d0_1234", 4'b1110, 7'b1001100);
    chk("d0_fs_low", 32'(fs0), 32'(0));
    chk("m1_lit_an", 32'(an1), 32'(1));
    goto(4);
    chk("m1_fs_wrap", 32'(fs1), 32'(1));
    goto(5);
    lit4("d0_hold", 4'b1110, 7'b1001100);
    chk("m1_fs_low", 32'(fs1), 32'(0));
    goto(6);
    lit4("d1_1234", 4'b1101, 7'b0000110);
    goto(8);
    digits = 16'h00A0;
    goto(10);
    lit4("d2_old", 4'b1011, 7'b0010010);
    goto(14);
    lit4("d3_old", 4'b0111, 7'b1001111);
    goto(17);
    chk("frame1_fs", 32'(fs0), 32'(1));
    goto(18);
    lit4("d0_new", 4'b1110, 7'b0000001);
    goto(22);
    lit4("d1_new", 4'b1101, 7'b0001000);
    digits = 16'h0070;
    blank_lz = 1'b1;
    goto(34);
    lit4("lz_d0", 4'b1110, 7'b0000001);
    goto(38);
    lit4("lz_d1", 4'b1101, 7'b0001111);
    goto(42);
    lit4("lz_d2", 4'b1011, 7'b1111111);
    goto(46);
    lit4("lz_d3", 4'b0111, 7'b1111111);
    digits = 16'h0000;
    goto(50);
    lit4("zero_d0", 4'b1110, 7'b0000001);
    goto(54);
    lit4("zero_d1", 4'b1101, 7'b1111111);
    dp_in = 4'b0100;
    digits = 16'h0005;
    goto(66);
    lit4("dp_d0", 4'b1110, 7'b0100100);
    chk("dp_d0_dp", 32'(dp0), 32'(1));
    goto(74);
    lit4("dp_d2", 4'b1011, 7'b1111111);
    chk("dp_d2_dp", 32'(dp0), 32'(0));
    goto(78);
    chk("dp_d3_dp", 32'(dp0), 32'(1));
    goto(80);
    en = 1'b0;
    goto(81);
    lit4("en_off", 4'b1111, 7'b1111111);
    chk("en_off_fs", 32'(fs0), 32'(1));
    chk("en_off_m1an", 32'(an1), 32'(0));
    goto(90);
    en = 1'b1;
    goto(91);
    lit4("en_back", 4'b1011, 7'b1111111);
    chk("en_back_dp", 32'(dp0), 32'(0));
    goto(93);
    #2 rst = 1'b1;
    #1;
    lit4("async_rst", 4'b1111, 7'b1111111);
    chk("async_rst_dp", 32'(dp0), 32'(1));
    chk("async_rst_fs", 32'(fs0), 32'(0));
    chk("async_rst_m1an", 32'(an1), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    digits = 16'h1234;
    dp_in = 4'b0000;
    blank_lz = 1'b0;
    rst = 1'b0;
    ed = 0;
    goto(1);
    chk("restart_fs", 32'(fs0), 32'(1));
    goto(2);
    lit4("restart_d0", 4'b1110, 7'b1001100);
    goto(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Takes packed 4-bit hex/BCD digits plus per-digit decimal points and scans one digit at a time.
- Drives a shared active-low segment bus and per-digit anode enables.
- Adds frame snapshotting (no tearing), optional leading-zero blanking and a display enable. Sits between the score/counter logic and the board pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant.
- SCAN_DIV, 50000, clock cycles each digit stays lit (>=2).
- AN_ACTIVE_LOW, 1, 1 = anode enable driven low when active, 0 = driven high.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- digits  input  4*N_DIGITS  packed digit values; digit i = digits[4i+3:4i].
- dp_in  input  N_DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  input  1  1 = blank leading zeros.
- en  input  1  0 = display dark; scanning continues.
- sseg  output  [0:6]  segments a..g, sseg[0]=a, sseg[6]=g, active-low.
- dp  output  1  decimal point, active-low.
- an  output  N_DIGITS  anode enables, polarity per AN_ACTIVE_LOW, one-hot active.
- frame_start  output  1  one-cycle pulse on each snapshot load.

Behaviour:
- Reset (async, immediate):
  - sseg=1111111, dp=1, all an inactive, frame_start=0.
  - Scan counter=0, digit index=0, snapshot=0, valid=0, load_pending=1.
- Scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the index increments; index N_DIGITS-1 wraps to 0.
- Snapshot load: digits/dp_in are copied into the snapshot registers at either of these edges:
  - the first edge with load_pending=1 (first edge after reset release), which clears load_pending and sets valid;
  - the edge where the counter wraps while index=N_DIGITS-1 (index -> 0).
- frame_start is registered and is 1 in the cycle following each load.
- Input changes mid-frame have no visible effect until the next load.
- Outputs are registered from snapshot[index] and lag the index by exactly one cycle.
  - While valid=0 they hold the reset (blank) values.
- Decode, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and snapshot digits N_DIGITS-1 down to i are all 0.
  - Digit 0 is never blanked.
  - A blanked digit shows sseg=1111111 and dp=!dp_snapshot[i], so a decimal point still shows. Its anode is still active.
- en=0: registered outputs forced to blank (sseg all 1, dp=1, all an inactive) from the next edge. Counter, index and snapshots keep running.
- Exactly one an bit is active at any time when valid=1 and en=1. There is no dead cycle between digits.
- N_DIGITS=1: index stays 0; a load occurs on every counter wrap.
- Reset asserted mid-scan: outputs blank immediately (async). After release, the sequence restarts at digit 0 with a fresh snapshot.

Decomposition:
- Shared package holds:
  - the 16-entry segment constant table;
  - SEG_BLANK = 7'b1111111;
  - the anode polarity helper function.
- One combinational sub-module, hex7seg_decode (4-bit in, [0:6] out, active-low), instantiated once on the muxed digit.
- Counter, index, snapshot and blanking logic live in sseg_scan_driver.

Test Plan:
- Reset/first frame (N_DIGITS=4, SCAN_DIV=4, digits=16'h1234, dp_in=0, en=1): first edge after release gives frame_start=1 the next cycle. From the 2nd edge: an=1110, sseg=1001100 (4) for 4 cycles, then an=1101 sseg=0000110, then 1011 0010010, then 0111 1001111, then wrap.
- Snapshot: change digits to 16'h00A0 mid-frame. Current frame keeps showing 1234. The next frame shows A on digit 1 (0001000) and 0 elsewhere (0000001).
- Blanking: digits=16'h0070, blank_lz=1. Digits 3 and 2 give sseg=1111111; digit 1 gives 0001111; digit 0 gives 0000001. With digits=0, only digit 0 lit as 0000001.
- Decimal point: dp_in=4'b0100, blank_lz=1, digits=16'h0005. Digit 2 is blank but dp=0; other digits dp=1.
- Enable/reset mid-scan: en=0 for 10 cycles gives an=1111 and sseg=1111111 from the next edge, and the index keeps advancing. Assert rst mid-digit: outputs blank the same cycle (no clock needed), then the scan restarts at digit 0.
- AN_ACTIVE_LOW=0, N_DIGITS=1: an toggles between 0 and 1 only per valid/en. frame_start pulses every SCAN_DIV cycles.
